// File: rtl/fetch_queue.sv
// Instruction-fetch stage with a DEPTH-entry prefetch queue, address-checked responses and replay.
// Optional same-cycle response forwarding into an empty queue: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
    parameter logic [31:0] START_ADDR = 32'h2000_0000,
    parameter int unsigned DEPTH      = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        FLUSH,
    input  logic [31:0] FLUSH_PC,
    input  logic        STALL,
    input  logic        MEM_WAIT,
    output logic        INST_RDEN,
    output logic [31:0] INST_RIADDR,
    input  logic [31:0] INST_ROADDR,
    input  logic        INST_RVALID,
    input  logic [31:0] INST_RDATA,
    output logic        INST_VALID,
    output logic [31:0] INST_PC,
    output logic [31:0] INST_DATA
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic [31:0]      req_pc;
    logic [31:0]      exp_pc;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [31:0]      q_pc   [DEPTH];
    logic [31:0]      q_data [DEPTH];

    logic [31:0] inflight;
    logic        active;
    logic        issue;
    logic        accept;
    logic        reject;
    logic        pop_en;
    logic        pop;
    logic        bypass;
    logic        wr;

    // Request/response/pop decisions for the current cycle
    always_comb begin
        inflight = (req_pc - exp_pc) >> 2;
        active   = !RST && !FLUSH && !MEM_WAIT;
        issue    = active && ((32'(count) + inflight) < 32'(DEPTH));
        accept   = active && INST_RVALID && (INST_ROADDR == exp_pc)
                   && (count < CNT_W'(DEPTH));
        reject   = active && INST_RVALID && !accept;
        pop_en   = active && !STALL;
        pop      = pop_en && (count != '0);
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass   = accept && pop_en && (count == '0);
`else
        bypass   = 1'b0;
`endif
        wr       = accept && !bypass;
    end

    assign INST_RDEN   = issue;
    assign INST_RIADDR = req_pc;

    // Fetch pointers and queue occupancy; a mismatched response rewinds req_pc
    always_ff @(posedge CLK) begin
        if (RST) begin
            req_pc <= START_ADDR;
            exp_pc <= START_ADDR;
            head   <= '0;
            tail   <= '0;
            count  <= '0;
        end else if (FLUSH) begin
            req_pc <= FLUSH_PC & 32'hFFFF_FFFC;
            exp_pc <= FLUSH_PC & 32'hFFFF_FFFC;
            head   <= '0;
            tail   <= '0;
            count  <= '0;
        end else if (!MEM_WAIT) begin
            if (reject) begin
                req_pc <= exp_pc;
            end else if (issue) begin
                req_pc <= req_pc + 32'd4;
            end
            if (accept) begin
                exp_pc <= exp_pc + 32'd4;
            end
            if (wr) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            count <= count + CNT_W'(wr) - CNT_W'(pop);
        end
    end

    // Queue storage; contents are only meaningful below count
    always_ff @(posedge CLK) begin
        if (wr) begin
            q_pc[tail]   <= exp_pc;
            q_data[tail] <= INST_RDATA;
        end
    end

    // Head entry (or forwarded response) to decode; NOP when empty
    always_comb begin
        INST_VALID = 1'b0;
        INST_PC    = '0;
        INST_DATA  = NOP;
        if (bypass) begin
            INST_VALID = 1'b1;
            INST_PC    = INST_ROADDR;
            INST_DATA  = INST_RDATA;
        end else if (count != '0) begin
            INST_VALID = 1'b1;
            INST_PC    = q_pc[head];
            INST_DATA  = q_data[head];
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming, fill/back-pressure, flush, mismatch replay, MEM_WAIT.
module tb_fetch_queue;

    localparam logic [31:0] S = 32'h2000_0000;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST, FLUSH, STALL, MEM_WAIT, INST_RVALID;
    logic [31:0] FLUSH_PC, INST_ROADDR, INST_RDATA;
    logic        INST_RDEN, INST_VALID;
    logic [31:0] INST_RIADDR, INST_PC, INST_DATA;

    int tests = 0;
    int fails = 0;
    bit auto_mem = 1'b0;
    int rq;

    fetch_queue #(.START_ADDR(S), .DEPTH(4)) dut (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .FLUSH_PC(FLUSH_PC),
        .STALL(STALL), .MEM_WAIT(MEM_WAIT),
        .INST_RDEN(INST_RDEN), .INST_RIADDR(INST_RIADDR),
        .INST_ROADDR(INST_ROADDR), .INST_RVALID(INST_RVALID), .INST_RDATA(INST_RDATA),
        .INST_VALID(INST_VALID), .INST_PC(INST_PC), .INST_DATA(INST_DATA)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] dat(input logic [31:0] a);
        return a ^ 32'hC3C3_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic resp(input logic v, input logic [31:0] a);
        INST_RVALID = v;
        INST_ROADDR = a;
        INST_RDATA  = dat(a);
    endtask

    // One clock; in auto mode the memory answers last cycle's request one cycle later
    task automatic step();
        logic        r;
        logic [31:0] a;
        @(negedge CLK);
        r = INST_RDEN;
        a = INST_RIADDR;
        @(posedge CLK);
        #1;
        if (auto_mem) resp(r, a);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; FLUSH = 1'b0; STALL = 1'b0; MEM_WAIT = 1'b0;
        auto_mem = 1'b0;
        resp(1'b0, 32'h0);
        step();
        RST = 1'b0;
        #1;
    endtask

    task automatic wait_valid(input int max_cyc, input string tag);
        int n = 0;
        while (INST_VALID !== 1'b1 && n < max_cyc) begin
            step();
            n++;
        end
        chk(tag, 32'(INST_VALID), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; FLUSH = 1'b0; FLUSH_PC = '0; STALL = 1'b0; MEM_WAIT = 1'b0;
        resp(1'b0, 32'h0);

        // Reset state
        step();
        chk("rst_rden",  32'(INST_RDEN),  32'd0);
        chk("rst_valid", 32'(INST_VALID), 32'd0);
        chk("rst_pc",    INST_PC,         32'h0);
        chk("rst_data",  INST_DATA,       32'h13);

        // Stream with a one-cycle memory
        RST = 1'b0; auto_mem = 1'b1;
        #1;
        chk("first_rden",  32'(INST_RDEN), 32'd1);
        chk("first_addr",  INST_RIADDR,    S);
        step();
        chk("lat_valid",   32'(INST_VALID), 32'(BYP));
        chk("second_addr", INST_RIADDR,     S + 32'h4);
        step();
        for (int i = 0; i < 4; i++) begin
            chk("stream_valid", 32'(INST_VALID), 32'd1);
            chk("stream_pc",    INST_PC,   S + 32'(4 * (i + int'(BYP))));
            chk("stream_data",  INST_DATA, dat(S + 32'(4 * (i + int'(BYP)))));
            step();
        end

        // Reset mid-stream with a response on the bus
        RST = 1'b1;
        #1;
        chk("midrst_rden", 32'(INST_RDEN), 32'd0);
        step();
        chk("midrst_valid", 32'(INST_VALID), 32'd0);
        chk("midrst_pc",    INST_PC,         32'h0);
        chk("midrst_data",  INST_DATA,       32'h13);

        // Fill under STALL: exactly DEPTH requests
        RST = 1'b0; STALL = 1'b1;
        #1;
        rq = 0;
        for (int i = 0; i < 8; i++) begin
            if (INST_RDEN === 1'b1) rq++;
            step();
        end
        chk("fill_req_count", 32'(rq),          32'd4);
        chk("fill_rden",      32'(INST_RDEN),   32'd0);
        chk("fill_valid",     32'(INST_VALID),  32'd1);
        chk("fill_pc",        INST_PC,          S);
        chk("fill_data",      INST_DATA,        dat(S));
        STALL = 1'b0;
        #1;
        chk("release_rden", 32'(INST_RDEN), 32'd0);
        chk("release_pc0",  INST_PC,        S);
        step();
        chk("resume_rden", 32'(INST_RDEN), 32'd1);
        chk("resume_addr", INST_RIADDR,    S + 32'h10);
        for (int i = 1; i < 5; i++) begin
            chk("drain_pc", INST_PC, S + 32'(4 * i));
            step();
        end

        // Flush with two requests in flight and stale responses afterwards
        do_reset();
        step(); resp(1'b1, S);          #1;
        step(); resp(1'b1, S + 32'h4);  #1;
        step(); resp(1'b0, 32'h0);      #1;
        chk("pre_flush_addr", INST_RIADDR, S + 32'hC);
        step(); resp(1'b1, S + 32'h8); FLUSH = 1'b1; FLUSH_PC = S + 32'h103; #1;
        chk("flush_rden", 32'(INST_RDEN), 32'd0);
        step(); resp(1'b1, S + 32'hC); FLUSH = 1'b0; #1;
        chk("redir_rden",  32'(INST_RDEN),  32'd1);
        chk("redir_addr",  INST_RIADDR,     S + 32'h100);
        chk("stale_valid", 32'(INST_VALID), 32'd0);
        step(); resp(1'b1, S + 32'h100); #1;
        chk("replay_addr",  INST_RIADDR,     S + 32'h100);
        chk("flush_byp_v",  32'(INST_VALID), 32'(BYP));
        chk("flush_byp_pc", INST_PC,         BYP ? S + 32'h100 : 32'h0);
        step(); resp(1'b0, 32'h0); #1;
        chk("flush_out_v",  32'(INST_VALID), 32'(!BYP));
        chk("flush_out_pc", INST_PC,         BYP ? 32'h0 : S + 32'h100);

        // Mismatched response address causes replay from the missing PC
        do_reset();
        step(); resp(1'b1, S);         #1;
        step(); resp(1'b1, S + 32'h8); #1;
        chk("mm_head_v",  32'(INST_VALID), 32'(!BYP));
        chk("mm_head_pc", INST_PC,         BYP ? 32'h0 : S);
        step(); resp(1'b0, 32'h0);     #1;
        chk("mm_rden",    32'(INST_RDEN),  32'd1);
        chk("mm_addr",    INST_RIADDR,     S + 32'h4);
        chk("mm_noenq_v", 32'(INST_VALID), 32'd0);
        step(); resp(1'b1, S + 32'h4); #1;
        chk("mm_byp_v",   32'(INST_VALID), 32'(BYP));
        chk("mm_byp_pc",  INST_PC,         BYP ? S + 32'h4 : 32'h0);
        step(); resp(1'b0, 32'h0);     #1;
        chk("mm_out_v",    32'(INST_VALID), 32'(!BYP));
        chk("mm_out_pc",   INST_PC,         BYP ? 32'h0 : S + 32'h4);
        chk("mm_out_data", INST_DATA,       BYP ? 32'h13 : dat(S + 32'h4));

        // MEM_WAIT for three cycles mid-stream; the lost word is re-fetched
        do_reset();
        auto_mem = 1'b1;
        for (int i = 0; i < 4; i++) step();
        MEM_WAIT = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("mw_rden",  32'(INST_RDEN),  32'd0);
            chk("mw_valid", 32'(INST_VALID), 32'(!BYP));
            chk("mw_pc",    INST_PC,         BYP ? 32'h0 : S + 32'h8);
            step();
        end
        MEM_WAIT = 1'b0;
        #1;
        chk("mw_after_rden", 32'(INST_RDEN),  32'd1);
        chk("mw_after_addr", INST_RIADDR,     S + 32'h10);
        chk("mw_after_pc",   INST_PC,         BYP ? 32'h0 : S + 32'h8);
        step();
        wait_valid(20, "mw_refetch_timeout");
        chk("mw_refetch_pc",   INST_PC,   S + 32'hC);
        chk("mw_refetch_data", INST_DATA, dat(S + 32'hC));
        step();
        wait_valid(20, "mw_next_timeout");
        chk("mw_next_pc", INST_PC, S + 32'h10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch stage with an N-entry prefetch queue. It is the next generation of the single-entry fetch stage and sits between the MMU instruction port and decode. It issues pipelined read requests ahead of consumption and tracks in-flight requests by PC distance. It discards stale or mismatched responses by address check and replays from the oldest missing PC, so the pipeline only ever sees in-order instructions.

## Interface
Parameters:
- START_ADDR, 32'h2000_0000, PC fetched first after reset; bits [1:0] must be 0.
- DEPTH, 4, queue entries; power of two, ≥2.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- FLUSH  in  1  redirect; clears queue, restarts fetch at FLUSH_PC.
- FLUSH_PC  in  32  redirect target; bits [1:0] forced to 0.
- STALL  in  1  downstream hold; no pop.
- MEM_WAIT  in  1  global freeze.
- INST_RDEN  out  1  read request strobe.
- INST_RIADDR  out  32  request address.
- INST_ROADDR  in  32  address of the returned word.
- INST_RVALID  in  1  response valid.
- INST_RDATA  in  32  returned instruction.
- INST_VALID  out  1  head entry is valid.
- INST_PC  out  32  PC of head entry.
- INST_DATA  out  32  instruction at head entry.

## Operation
- State: req_pc (next address to request), exp_pc (PC of the next entry to enqueue), circular queue with head/tail pointers, and count (width $clog2(DEPTH+1)).
- In-flight count is (req_pc − exp_pc) >> 2. It is 32-bit modular, so no separate counter exists.
- Issue: INST_RDEN = !RST && !FLUSH && !MEM_WAIT && (count + inflight < DEPTH). INST_RIADDR = req_pc. On issue, req_pc += 4.
- Accept condition: INST_RVALID && INST_ROADDR == exp_pc && count < DEPTH && !MEM_WAIT && !FLUSH. On accept, write {exp_pc, INST_RDATA} at tail, advance tail, and set exp_pc += 4.
- Reject: if INST_RVALID is high and the response is not accepted (and neither FLUSH nor MEM_WAIT is active), set req_pc <= exp_pc (replay). This rewind has priority over the same-cycle issue increment.
- Pop: when count > 0 && !STALL && !MEM_WAIT && !FLUSH, advance head.
- Accept and pop can occur in the same cycle; count stays unchanged.
- Outputs come combinationally from the head entry. When the queue is empty: INST_VALID = 0, INST_PC = 0, INST_DATA = 32'h0000_0013 (NOP).
- Priority order: RST > FLUSH > MEM_WAIT > normal operation.
  - FLUSH: queue emptied, req_pc = exp_pc = FLUSH_PC, and any response in the same cycle is ignored.
  - MEM_WAIT: all state frozen, with no issue, accept or pop. A response arriving during MEM_WAIT is lost and is recovered later by the replay rule.
- The pointers wrap modulo DEPTH. Full condition: count == DEPTH. Empty condition: count == 0.

## Timing
- Reset values: queue empty; req_pc = exp_pc = START_ADDR; INST_RDEN = 0 while RST is high; INST_VALID = 0, INST_PC = 0, INST_DATA = 32'h13.
- First request: INST_RDEN = 1 with INST_RIADDR = START_ADDR in the first cycle after RST deasserts.
- Latency: a response accepted in cycle N appears at the outputs (INST_VALID = 1) in cycle N+1.
- Redirect: FLUSH in cycle N gives INST_RDEN with INST_RIADDR = FLUSH_PC in cycle N+1. INST_VALID is 0 from N+1 until the first matching response has been enqueued.
- Throughput: with a one-cycle-response memory and no stall, one instruction per cycle.
- Back-pressure: issue stops once the queued plus in-flight count reaches DEPTH, and resumes in the cycle after a pop.
- RST asserted mid-operation: all state returns to its reset values at the next edge, and responses in that cycle are ignored.

## Configuration
- FETCH_QUEUE_BYPASS_EN: when defined, a response that meets the accept condition while count == 0 and pop is enabled is forwarded combinationally in the same cycle.
  - In that cycle the outputs show INST_VALID = 1 and the INST_ROADDR/INST_RDATA values.
  - The word is consumed without being written to the queue; exp_pc still advances.
  - Latency from response to output is 0.
- Without the macro, every instruction passes through the queue, and latency is always 1 cycle.

## Test plan
- Reset then stream: START_ADDR = 0x2000_0000 with a 1-cycle-response memory, no stall -> INST_PC = 0x2000_0000, 0x2000_0004, … on consecutive cycles with INST_VALID = 1, one per cycle after initial latency.
- Fill: DEPTH = 4, STALL held high -> exactly 4 requests issued, then INST_RDEN = 0; INST_PC stays 0x2000_0000. Release STALL -> 4 sequential PCs, and issue resumes after the first pop.
- Flush with stale data: 2 requests in flight, FLUSH with FLUSH_PC = 0x2000_0100 -> next INST_RIADDR = 0x2000_0100; late responses for 0x2000_0008/0x2000_000C are dropped; the first valid output has INST_PC = 0x2000_0100.
- Mismatch replay: respond to a request for 0x2000_0004 with INST_ROADDR = 0x2000_0008 -> entry not enqueued; the next INST_RIADDR is 0x2000_0004; the output order stays sequential.
- MEM_WAIT: asserted for 3 cycles mid-stream with responses presented -> no change to INST_PC, no INST_RDEN, no pop; lost words are re-requested afterward.
- Bypass, with FETCH_QUEUE_BYPASS_EN defined: empty queue and a matching response for 0x2000_0000 -> INST_VALID = 1 and INST_PC = 0x2000_0000 in the same cycle. Without the macro, the same stimulus produces this one cycle later.
